// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frame parser behind uart_byte_rx.
// Writes payloads to a buffer and hands frames to the host via valid/ack.
module uart_rx_frame_ctrl #(
    parameter int         MAX_LEN     = 16,
    parameter int         ADDR_W      = 4,
    parameter int         TIMEOUT_CYC = 200000,
    parameter logic [7:0] SOF_BYTE    = 8'hAA,
    parameter logic [7:0] BAUD_CMD    = 8'h01
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Rx_Done,
    input  logic [7:0]        data_byte,
    output logic [2:0]        baud_set,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_valid,
    output logic [7:0]        frame_cmd,
    output logic [7:0]        frame_len,
    input  logic              frame_ack,
    output logic              frame_err,
    output logic [2:0]        err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_LEN, S_DATA, S_CHK, S_DONE
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [8:0] MAX_LEN9 = 9'(MAX_LEN);

    state_t state, state_n;

    logic [CNT_W-1:0] tmo_cnt;
    logic [7:0]       cmd_q, len_q, idx_q, chk_q;
    logic [2:0]       first_q;

    logic       in_frame, expire, len_bad, last_byte, chk_ok, is_sof;
    logic       err_set, wr_set;
    logic [2:0] err_val;

    always_comb begin
        in_frame  = state inside {S_CMD, S_LEN, S_DATA, S_CHK};
        expire    = in_frame && !Rx_Done && (tmo_cnt == CNT_LAST);
        len_bad   = {1'b0, data_byte} > MAX_LEN9;
        last_byte = idx_q == (len_q - 8'd1);
        chk_ok    = data_byte == chk_q;
        is_sof    = data_byte == SOF_BYTE;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (expire) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:
                    if (Rx_Done && is_sof && !frame_valid)
                        state_n = S_CMD;
                S_CMD:
                    if (Rx_Done) state_n = S_LEN;
                S_LEN:
                    if (Rx_Done) begin
                        if (len_bad)                 state_n = S_IDLE;
                        else if (data_byte == 8'd0)  state_n = S_CHK;
                        else                         state_n = S_DATA;
                    end
                S_DATA:
                    if (Rx_Done && last_byte) state_n = S_CHK;
                S_CHK:
                    if (Rx_Done) state_n = chk_ok ? S_DONE : S_IDLE;
                S_DONE:
                    state_n = S_IDLE;
                default:
                    state_n = S_IDLE;
            endcase
        end
    end

    // Error and write decisions for the current cycle
    always_comb begin
        err_set = 1'b0;
        err_val = 3'd0;
        wr_set  = Rx_Done && (state == S_DATA);
        if (expire) begin
            err_set = 1'b1;
            err_val = 3'd3;
        end else if (Rx_Done) begin
            case (state)
                S_IDLE:
                    if (is_sof && frame_valid) begin
                        err_set = 1'b1;
                        err_val = 3'd4;
                    end
                S_LEN:
                    if (len_bad) begin
                        err_set = 1'b1;
                        err_val = 3'd2;
                    end
                S_CHK:
                    if (!chk_ok) begin
                        err_set = 1'b1;
                        err_val = 3'd1;
                    end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tmo_cnt     <= '0;
            cmd_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            chk_q       <= '0;
            first_q     <= '0;
            baud_set    <= 3'd0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_valid <= 1'b0;
            frame_cmd   <= '0;
            frame_len   <= '0;
            frame_err   <= 1'b0;
            err_code    <= '0;
        end else begin
            if (Rx_Done || !in_frame) tmo_cnt <= '0;
            else                      tmo_cnt <= tmo_cnt + CNT_W'(1);

            frame_err <= err_set;
            if (err_set) err_code <= err_val;

            wr_en <= wr_set;
            if (wr_set) begin
                wr_addr <= ADDR_W'(idx_q);
                wr_data <= data_byte;
            end

            if (Rx_Done) begin
                case (state)
                    S_CMD: begin
                        cmd_q <= data_byte;
                        chk_q <= data_byte;
                    end
                    S_LEN: begin
                        len_q <= data_byte;
                        chk_q <= chk_q ^ data_byte;
                        idx_q <= 8'd0;
                    end
                    S_DATA: begin
                        chk_q <= chk_q ^ data_byte;
                        idx_q <= idx_q + 8'd1;
                        if (idx_q == 8'd0) first_q <= data_byte[2:0];
                    end
                    default: ;
                endcase
            end

            if (state == S_DONE) begin
                frame_valid <= 1'b1;
                frame_cmd   <= cmd_q;
                frame_len   <= len_q;
                if (cmd_q == BAUD_CMD && len_q == 8'd1)
                    baud_set <= first_q;
            end else if (frame_ack) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed and random frames for uart_rx_frame_ctrl.
// Expected results come from frame fields, not from the parser's states.
module tb_uart_rx_frame_ctrl;

    localparam int MAXL = 16;
    localparam int AW   = 4;
    localparam int TMO  = 40;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          Rx_Done = 1'b0;
    logic [7:0]    data_byte = 8'h00;
    logic [2:0]    baud_set;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_valid;
    logic [7:0]    frame_cmd;
    logic [7:0]    frame_len;
    logic          frame_ack = 1'b0;
    logic          frame_err;
    logic [2:0]    err_code;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] wr_q[$];
    logic [2:0]  err_q[$];
    logic [7:0]  pl[0:255];
    logic [2:0]  exp_baud = 3'd0;

    uart_rx_frame_ctrl #(
        .MAX_LEN(MAXL),
        .ADDR_W(AW),
        .TIMEOUT_CYC(TMO),
        .SOF_BYTE(8'hAA),
        .BAUD_CMD(8'h01)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .Rx_Done(Rx_Done),
        .data_byte(data_byte),
        .baud_set(baud_set),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .frame_valid(frame_valid),
        .frame_cmd(frame_cmd),
        .frame_len(frame_len),
        .frame_ack(frame_ack),
        .frame_err(frame_err),
        .err_code(err_code)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (wr_en) wr_q.push_back({8'(wr_addr), wr_data});
        if (frame_err) err_q.push_back(err_code);
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge Clk);
        #1;
        Rx_Done   = 1'b1;
        data_byte = b;
        @(posedge Clk);
        #1;
        Rx_Done   = 1'b0;
        data_byte = 8'($urandom);
    endtask

    task automatic do_ack();
        frame_ack = 1'b1;
        @(posedge Clk);
        #1;
        frame_ack = 1'b0;
        check("ack_clear", frame_valid, 0);
    endtask

    // chk_force < 0 sends the correct checksum
    task automatic run_frame(input logic [7:0] cmd, input int len,
                             input int chk_force, input bit ack);
        logic [7:0] c;
        logic [7:0] chk_b;
        int exp_err;
        int nwr;
        c = cmd ^ 8'(len);
        for (int i = 0; i < len; i++) c ^= pl[i];
        chk_b = (chk_force >= 0) ? 8'(chk_force) : c;
        exp_err = (len > MAXL) ? 2 : ((chk_b != c) ? 1 : 0);
        nwr = (len > MAXL) ? 0 : len;
        wr_q.delete();
        err_q.delete();
        send_byte(8'hAA);
        idle($urandom_range(0, 3));
        send_byte(cmd);
        idle($urandom_range(0, 3));
        send_byte(8'(len));
        if (len <= MAXL) begin
            for (int i = 0; i < len; i++) begin
                idle($urandom_range(0, 3));
                send_byte(pl[i]);
            end
            idle($urandom_range(0, 3));
            send_byte(chk_b);
        end
        idle(2);
        check("err_count", err_q.size(), (exp_err != 0) ? 1 : 0);
        if (err_q.size() > 0) check("err_code", err_q[0], exp_err);
        check("wr_count", wr_q.size(), nwr);
        for (int i = 0; i < nwr && i < wr_q.size(); i++)
            check("wr_entry", wr_q[i], {8'(i), pl[i]});
        if (exp_err == 0) begin
            if (cmd == 8'h01 && len == 1) exp_baud = pl[0][2:0];
            check("valid", frame_valid, 1);
            check("cmd", frame_cmd, cmd);
            check("len", frame_len, len);
            check("baud", baud_set, exp_baud);
            if (ack) do_ack();
        end else begin
            check("no_valid", frame_valid, 0);
            check("baud_kept", baud_set, exp_baud);
        end
    endtask

    initial begin
        idle(3);
        check("rst_baud", baud_set, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_err", {frame_err, err_code}, 0);
        check("rst_frame", {frame_cmd, frame_len}, 0);
        Rst_n = 1'b1;
        idle(2);

        // frame 10 03 11 22 33, checksum 13, with latency checks
        wr_q.delete();
        err_q.delete();
        send_byte(8'hAA);
        send_byte(8'h10);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h13);
        check("lat_early", frame_valid, 0);
        idle(1);
        check("lat_rise", frame_valid, 1);
        check("f1_cmd", frame_cmd, 8'h10);
        check("f1_len", frame_len, 8'h03);
        check("f1_wr_n", wr_q.size(), 3);
        if (wr_q.size() == 3) begin
            check("f1_wr0", wr_q[0], 16'h0011);
            check("f1_wr1", wr_q[1], 16'h0122);
            check("f1_wr2", wr_q[2], 16'h0233);
        end
        check("f1_no_err", err_q.size(), 0);
        idle(5);
        check("f1_hold", frame_valid, 1);
        do_ack();

        // baud reprogram, then a zero-length baud command
        pl[0] = 8'h05;
        run_frame(8'h01, 1, -1, 1'b1);
        check("baud5", baud_set, 3'd5);
        run_frame(8'h01, 0, -1, 1'b1);
        check("baud_len0", baud_set, 3'd5);

        // bad checksum, then a good frame
        pl[0] = 8'h44;
        pl[1] = 8'h55;
        run_frame(8'h20, 2, 0, 1'b1);
        run_frame(8'h21, 2, -1, 1'b1);

        // oversize length, trailing byte discarded
        run_frame(8'h20, 17, -1, 1'b1);
        wr_q.delete();
        err_q.delete();
        send_byte(8'h20);
        idle(2);
        check("disc_err", err_q.size(), 0);
        check("disc_wr", wr_q.size(), 0);
        check("disc_valid", frame_valid, 0);

        // timeout at expiry
        err_q.delete();
        send_byte(8'hAA);
        send_byte(8'h30);
        idle(TMO - 1);
        check("tmo_before", frame_err, 0);
        idle(1);
        check("tmo_fire", frame_err, 1);
        check("tmo_code", err_code, 3'd3);
        idle(1);
        check("tmo_pulse", frame_err, 0);

        // byte lands on the expiry cycle
        err_q.delete();
        send_byte(8'hAA);
        send_byte(8'h30);
        idle(TMO - 2);
        send_byte(8'h00);
        check("tmo_saved", frame_err, 0);
        send_byte(8'h30);
        idle(1);
        check("tmo_valid", frame_valid, 1);
        check("tmo_cmd", frame_cmd, 8'h30);
        check("tmo_no_err", err_q.size(), 0);
        do_ack();

        // overrun while a frame is pending
        pl[0] = 8'h7E;
        run_frame(8'h42, 1, -1, 1'b0);
        send_byte(8'hAA);
        check("ovr_err", frame_err, 1);
        check("ovr_code", err_code, 3'd4);
        check("ovr_valid", frame_valid, 1);
        check("ovr_cmd", frame_cmd, 8'h42);
        @(posedge Clk);
        #1;
        Rx_Done   = 1'b1;
        data_byte = 8'hAA;
        frame_ack = 1'b1;
        @(posedge Clk);
        #1;
        Rx_Done   = 1'b0;
        frame_ack = 1'b0;
        check("ovr_ack_err", frame_err, 1);
        check("ovr_ack_code", err_code, 3'd4);
        check("ovr_ack_clr", frame_valid, 0);
        idle(2);

        // reset in the middle of the payload
        pl[0] = 8'h03;
        run_frame(8'h01, 1, -1, 1'b0);
        send_byte(8'hAA);
        send_byte(8'h40);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        Rst_n = 1'b0;
        #2;
        exp_baud = 3'd0;
        check("mrst_baud", baud_set, 0);
        check("mrst_valid", frame_valid, 0);
        check("mrst_wr", {wr_en, wr_addr, wr_data}, 0);
        check("mrst_frame", {frame_cmd, frame_len}, 0);
        check("mrst_err", {frame_err, err_code}, 0);
        idle(2);
        Rst_n = 1'b1;
        idle(1);
        pl[0] = 8'h9C;
        pl[1] = 8'hAA;
        run_frame(8'h55, 2, -1, 1'b1);

        // random frames
        for (int k = 0; k < 40; k++) begin
            int len;
            int cf;
            logic [7:0] cmd;
            len = $urandom_range(0, MAXL + 2);
            if ($urandom_range(0, 3) == 0) len = 1;
            cmd = ($urandom_range(0, 2) == 0) ? 8'h01 : 8'($urandom);
            for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
            cf = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : -1;
            run_frame(cmd, len, cf, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Frame-level controller behind the UART byte receiver (uart_byte_rx).
- Consumes the receiver's byte strobe (Rx_Done) and byte (data_byte), parses framed commands, writes payload bytes to an external buffer and hands completed frames to the host logic through a valid/ack handshake.
- Owns the receiver's baud_set configuration; a dedicated command frame reprograms it.

Parameters:
- MAX_LEN, 16, largest accepted payload length in bytes (1..256).
- ADDR_W, 4, payload buffer address width; must satisfy 2^ADDR_W >= MAX_LEN.
- TIMEOUT_CYC, 200000, maximum idle Clk cycles between bytes inside a frame.
- SOF_BYTE, 8'hAA, start-of-frame marker.
- BAUD_CMD, 8'h01, command code that reprograms baud_set.

Ports:
- Clk  input  1  system clock.
- Rst_n  input  1  asynchronous active-low reset.
- Rx_Done  input  1  one-cycle strobe from byte receiver; data_byte valid this cycle.
- data_byte  input  8  received byte.
- baud_set  output  3  baud select driven to byte receiver.
- wr_en  output  1  payload buffer write strobe.
- wr_addr  output  ADDR_W  payload buffer write address.
- wr_data  output  8  payload buffer write data.
- frame_valid  output  1  completed frame available; held until acked.
- frame_cmd  output  8  command byte of completed frame.
- frame_len  output  8  payload length of completed frame.
- frame_ack  input  1  host consumed frame.
- frame_err  output  1  one-cycle error pulse.
- err_code  output  3  error cause; valid with frame_err and held until next error.

Behaviour:
- Reset (async, Rst_n low):
  - All outputs 0 except baud_set = 3'd0.
  - State IDLE; timeout counter, byte index and checksum cleared.
- Frame format: SOF, CMD, LEN, LEN payload bytes, CHK.
- Checksum: CHK = XOR of CMD, LEN and all payload bytes. SOF is excluded.
- Bytes are accepted only in cycles where Rx_Done = 1; all other cycles advance only the timeout counter.
- States:
  - IDLE:
    - data_byte == SOF_BYTE and frame_valid == 0 -> CMD.
    - data_byte == SOF_BYTE and frame_valid == 1 -> frame_err, err_code 4 (overrun); stay in IDLE.
    - Any other byte is discarded.
  - CMD: latch cmd, chk <= byte -> LEN.
  - LEN:
    - Byte > MAX_LEN -> frame_err, err_code 2 -> IDLE.
    - Otherwise latch len, chk ^= byte.
    - len == 0 -> CHK; otherwise -> DATA with idx = 0.
  - DATA:
    - Each byte: registered write, so wr_en = 1, wr_addr = idx, wr_data = byte in the cycle after Rx_Done.
    - chk ^= byte, idx++.
    - Last byte (idx == len-1) -> CHK.
  - CHK:
    - Byte == chk -> DONE.
    - Otherwise -> frame_err, err_code 1 -> IDLE. Payload already written is not retracted.
  - DONE (one cycle):
    - frame_valid <= 1; frame_cmd and frame_len updated.
    - If cmd == BAUD_CMD and len == 1: baud_set <= first payload byte [2:0], updated the same cycle frame_valid rises.
    - -> IDLE.
- Latency: frame_valid rises 2 cycles after the Rx_Done of the CHK byte.
- frame_valid handshake:
  - Stays 1 until a cycle with frame_ack = 1, then clears next cycle.
  - frame_cmd and frame_len stay stable while frame_valid = 1.
  - frame_ack while frame_valid = 0 is ignored.
- Timeout:
  - Counter cleared on every Rx_Done and while in IDLE.
  - In CMD, LEN, DATA or CHK, count reaching TIMEOUT_CYC-1 -> frame_err, err_code 3 -> IDLE.
  - Rx_Done in the same cycle as expiry: the byte wins and the counter clears.
- Simultaneous events:
  - Ack and a new SOF in the same cycle: the SOF counts as overrun. frame_valid is sampled before the ack takes effect.
- Reset mid-frame: immediate return to IDLE. baud_set reverts to 0.

Test Plan:
- Frame AA 10 03 11 22 33 CHK = 10^03^11^22^33 = 0x13 -> three writes addr 0,1,2, data 11,22,33; frame_valid 2 cycles after last Rx_Done; frame_cmd = 0x10, frame_len = 3; clears one cycle after frame_ack.
- Frame AA 01 01 05 CHK = 0x05 -> baud_set = 3'd5 when frame_valid rises; frame AA 01 00 01 (len 0) -> baud_set unchanged.
- Frame AA 20 02 44 55 with bad CHK 0x00 -> frame_err with err_code 1, no frame_valid; next good frame accepted normally.
- Frame AA 20 11 (LEN 17 > MAX_LEN) -> err_code 2, return to IDLE; following byte 0x20 is discarded.
- Frame AA 30, then no Rx_Done for TIMEOUT_CYC cycles -> err_code 3 exactly at expiry; same stimulus with a byte on the expiry cycle -> no error.
- Unacked frame_valid, then new SOF -> err_code 4, frame_cmd unchanged; Rst_n pulsed mid-DATA -> all outputs 0, baud_set 0.
